mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the byte-wide data memory interface, placed in the MEM stage of the MIPS pipeline.
- Accepts one load or store per instruction: byte, halfword or word, with sign or zero extension on loads.
- Sequences it as consecutive single-byte memory accesses, assembling or splitting 32-bit data big-endian.
- Holds the pipeline with stall until the access completes.

Parameters:
- ADDRESSL, 32, width of byte address
- WORD, 8, memory data width (byte); block supports only 8
- DATAW, 32, CPU data width

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  MEM stage holds a load/store
- req_write  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=halfword, 10=word; 11 is treated as word
- req_signed  input  1  sign-extend load result (byte/half only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low-order bytes are used for byte/half
- stall  output  1  hold pipeline registers
- resp_valid  output  1  one-cycle completion pulse
- resp_error  output  1  misaligned access flag, valid with resp_valid
- resp_rdata  output  32  load result, valid with resp_valid
- mem_address  output  32  to memory address
- mem_write_data  output  8  to memory writeData
- mem_read  output  1  to memory memRead
- mem_write  output  1  to memory memWrite
- mem_read_data  input  8  from memory readData (combinational read)

Behaviour:
- Reset (async, rst=1): state IDLE, byte index 0, data buffer 0. All outputs 0, including stall, resp_*, and mem_*.
- States: IDLE, ACCESS, DONE.
- Byte count N: 1 (byte), 2 (half), 4 (word).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, req_valid=1: latch req_* into internal registers and set idx=0.
  - Aligned: next state ACCESS.
  - Misaligned: next state DONE with error=1.
- IDLE, req_valid=0: no action, all strobes 0.
- ACCESS drive, all signals from registers so they are glitch-free:
  - mem_address = latched_addr + idx.
  - Store: mem_write=1, mem_read=0, mem_write_data = byte (N-1-idx) of latched wdata. Big-endian: the MS byte goes to the lowest address.
  - Load: mem_read=1, mem_write=0, mem_write_data=0.
  - mem_read and mem_write are never both 1.
- ACCESS edge:
  - Load: shift mem_read_data into the buffer: buf = {buf[23:0], mem_read_data}.
  - idx increments each edge. When idx==N-1, go to DONE.
- DONE, one cycle: resp_valid=1, all strobes 0, then return to IDLE.
  - resp_rdata for a load: buffer extended per req_signed and size; word is unextended.
  - resp_rdata for a store or an error: 0.
  - resp_error=1 only for misaligned requests.
- stall = (IDLE & req_valid) | ACCESS. It is combinational, and 0 in DONE so the pipeline advances on the DONE edge.
- No request is accepted in DONE: the same instruction is still present on req_*.
- Latency from the accept cycle to resp_valid:
  - Word: 5 cycles (stall high 5 cycles).
  - Half: 3 cycles.
  - Byte: 2 cycles.
  - Misaligned: 1 cycle, no memory strobes.
- req_* changes during ACCESS are ignored because the values are latched.
- Address wrap: latched_addr + idx wraps modulo 2^32. For aligned requests this cannot cross 0xFFFFFFFF.
- Reset mid-operation: strobes drop immediately and the FSM returns to IDLE. Bytes already written stay in memory and no response is issued.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. The gap is one cycle with no strobes.

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.
- Store word 0xDEADBEEF at 0x10 -> four ACCESS cycles writing 0xDE@0x10, 0xAD@0x11, 0xBE@0x12, 0xEF@0x13. stall high 5 cycles, resp_valid pulses once with resp_error=0.
- Load word from 0x10 after the previous store -> four read cycles at 0x10..0x13, then resp_rdata=0xDEADBEEF with resp_valid one cycle.
- Load byte signed from 0x12 (0xBE) -> resp_rdata=0xFFFFFFBE. The unsigned load -> 0x000000BE. Latency 2 cycles.
- Store half 0x1234 at 0x20, then load half signed from 0x20 -> bytes 0x12@0x20 and 0x34@0x21, resp_rdata=0x00001234. Load word from 0x22 -> resp_error=1, resp_rdata=0, mem_read never asserted.
- Assert rst during the 2nd ACCESS cycle of a word store -> only 0x10 is written, no resp_valid. After reset release, a new request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a byte-wide data memory.
// Turns one CPU load/store (byte/half/word) into consecutive single-byte
// accesses, big-endian (MS byte at the lowest address), and stalls the
// pipeline until the access completes.
// Ports:
//   clk, rst                   clock, async active-high reset
//   req_valid/write/size/signed/addr/wdata   request from the MEM stage
//   stall                      hold pipeline registers (combinational)
//   resp_valid/error/rdata     one-cycle completion (registered)
//   mem_address/write_data/read/write   registered memory strobes
//   mem_read_data              combinational read data from memory
module mem_access_unit #(
  parameter int unsigned ADDRESSL = 32,
  parameter int unsigned WORD     = 8,
  parameter int unsigned DATAW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDRESSL-1:0] req_addr,
  input  logic [DATAW-1:0]    req_wdata,
  output logic                stall,
  output logic                resp_valid,
  output logic                resp_error,
  output logic [DATAW-1:0]    resp_rdata,
  output logic [ADDRESSL-1:0] mem_address,
  output logic [WORD-1:0]     mem_write_data,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [WORD-1:0]     mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state;
  logic [1:0]           idx;
  logic [1:0]           last_q;
  logic [ADDRESSL-1:0]  addr_q;
  logic [DATAW-1:0]     wdata_q;
  logic [DATAW-1:0]     buf_q;
  logic [1:0]           size_q;
  logic                 write_q;
  logic                 signed_q;

  logic [1:0]           req_last_c;
  logic                 req_mis_c;
  logic [1:0]           idx_inc_c;
  logic [DATAW-1:0]     buf_next_c;

  // Byte sel of a store word, sel counted from the LS byte.
  function automatic logic [WORD-1:0] pick(input logic [DATAW-1:0] d,
                                           input logic [1:0] sel);
    return d[WORD*int'(sel) +: WORD];
  endfunction

  // Load result extension; size 11 behaves as a word.
  function automatic logic [DATAW-1:0] extend(input logic [DATAW-1:0] b,
                                              input logic [1:0] sz,
                                              input logic sgn);
    case (sz)
      2'b00:   return {{(DATAW-8){sgn & b[7]}}, b[7:0]};
      2'b01:   return {{(DATAW-16){sgn & b[15]}}, b[15:0]};
      default: return b;
    endcase
  endfunction

  // Index of the final byte of the incoming request and its alignment.
  always_comb begin
    case (req_size)
      2'b00:   req_last_c = 2'd0;
      2'b01:   req_last_c = 2'd1;
      default: req_last_c = 2'd3;
    endcase
    req_mis_c = ((req_size == 2'b01) && req_addr[0]) ||
                (req_size[1] && (req_addr[1:0] != 2'b00));
  end

  assign idx_inc_c  = idx + 2'd1;
  assign buf_next_c = {buf_q[DATAW-WORD-1:0], mem_read_data};

  // Gated by rst so every output reads 0 while reset is held.
  assign stall = ~rst & (((state == IDLE) && req_valid) || (state == ACCESS));

  // FSM with registered memory strobes and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 2'd0;
      last_q         <= 2'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      buf_q          <= '0;
      size_q         <= 2'b00;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx      <= 2'd0;
            last_q   <= req_last_c;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            buf_q    <= '0;
            if (req_mis_c) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              // Present the first byte access already on entry to ACCESS.
              state          <= ACCESS;
              mem_address    <= req_addr;
              mem_read       <= ~req_write;
              mem_write      <= req_write;
              mem_write_data <= req_write ? pick(req_wdata, req_last_c) : '0;
            end
          end
        end

        ACCESS: begin
          if (!write_q) buf_q <= buf_next_c;
          if (idx == last_q) begin
            state          <= DONE;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            resp_valid     <= 1'b1;
            resp_error     <= 1'b0;
            resp_rdata     <= write_q ? '0 : extend(buf_next_c, size_q, signed_q);
          end else begin
            idx            <= idx_inc_c;
            mem_address    <= addr_q + ADDRESSL'(idx_inc_c);
            mem_write_data <= write_q ? pick(wdata_q, last_q - idx_inc_c) : '0;
          end
        end

        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
